// File: rtl/alu_cdb_unit.sv
// Integer execution unit: one-entry execute stage feeding a result FIFO
// that drains onto the common data bus under arbiter grant.
module alu_cdb_unit #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [4:0] NONE       = 5'b11111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rs_valid,
  input  logic [5:0]  alu_opcode,
  input  logic [31:0] alu_op1,
  input  logic [31:0] alu_op2,
  input  logic [4:0]  alu_dest_tag,
  output logic        alu_ready,
  output logic        cdb_req,
  input  logic        cdb_grant,
  output logic        cdb_valid,
  output logic [4:0]  cdb_tag,
  output logic [31:0] cdb_data,
  output logic        illegal_op
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_XOR  = 6'h04;
  localparam logic [5:0] OP_NOR  = 6'h05;
  localparam logic [5:0] OP_SLT  = 6'h06;
  localparam logic [5:0] OP_SLTU = 6'h07;
  localparam logic [5:0] OP_SLL  = 6'h08;
  localparam logic [5:0] OP_SRL  = 6'h09;
  localparam logic [5:0] OP_SRA  = 6'h0A;
  localparam logic [5:0] OP_LUI  = 6'h0B;

  logic          r_ex_valid;
  logic [5:0]    r_ex_op;
  logic [31:0]   r_ex_a;
  logic [31:0]   r_ex_b;
  logic [4:0]    r_ex_tag;

  logic [4:0]    r_fifo_tag  [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [31:0]   w_result;
  logic          w_illegal;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_occ;

  // Ready counts the execute slot so a push can never find the FIFO full
  assign w_occ     = {1'b0, r_count} + {{CW{1'b0}}, r_ex_valid};
  assign alu_ready = w_occ < (CW+1)'(FIFO_DEPTH);
  assign cdb_req   = r_count != '0;
  assign w_accept  = rs_valid && alu_ready;
  assign w_push    = r_ex_valid && (r_ex_tag != NONE);
  assign w_pop     = cdb_req && cdb_grant;

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (r_ex_op)
      OP_ADD:  w_result = r_ex_a + r_ex_b;
      OP_SUB:  w_result = r_ex_a - r_ex_b;
      OP_AND:  w_result = r_ex_a & r_ex_b;
      OP_OR:   w_result = r_ex_a | r_ex_b;
      OP_XOR:  w_result = r_ex_a ^ r_ex_b;
      OP_NOR:  w_result = ~(r_ex_a | r_ex_b);
      OP_SLT:  w_result = {31'b0, $signed(r_ex_a) < $signed(r_ex_b)};
      OP_SLTU: w_result = {31'b0, r_ex_a < r_ex_b};
      OP_SLL:  w_result = r_ex_a << r_ex_b[4:0];
      OP_SRL:  w_result = r_ex_a >> r_ex_b[4:0];
      OP_SRA:  w_result = $unsigned($signed(r_ex_a) >>> r_ex_b[4:0]);
      OP_LUI:  w_result = {r_ex_b[15:0], 16'b0};
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_tag   <= NONE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      cdb_valid  <= 1'b0;
      cdb_tag    <= NONE;
      cdb_data   <= '0;
      illegal_op <= 1'b0;
    end else begin
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_ex_op  <= alu_opcode;
        r_ex_a   <= alu_op1;
        r_ex_b   <= alu_op2;
        r_ex_tag <= alu_dest_tag;
      end
      illegal_op <= r_ex_valid && w_illegal;
      if (w_push) begin
        r_fifo_tag[r_wr_ptr]  <= r_ex_tag;
        r_fifo_data[r_wr_ptr] <= w_result;
        r_wr_ptr              <= r_wr_ptr + PW'(1);
      end
      cdb_valid <= w_pop;
      if (w_pop) begin
        cdb_tag  <= r_fifo_tag[r_rd_ptr];
        cdb_data <= r_fifo_data[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: tb/tb_alu_cdb_unit.sv
// Directed bench for alu_cdb_unit: latency, ALU ops, backpressure,
// null-tag drop, illegal opcode and mid-stream reset.
module tb_alu_cdb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rs_valid;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [4:0]  alu_dest_tag;
  logic        alu_ready;
  logic        cdb_req;
  logic        cdb_grant;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        illegal_op;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_cdb_unit dut (
    .clk          (clk),
    .rst          (rst),
    .rs_valid     (rs_valid),
    .alu_opcode   (alu_opcode),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_dest_tag (alu_dest_tag),
    .alu_ready    (alu_ready),
    .cdb_req      (cdb_req),
    .cdb_grant    (cdb_grant),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .illegal_op   (illegal_op)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    rs_valid     = 1'b1;
    alu_opcode   = op;
    alu_op1      = a;
    alu_op2      = b;
    alu_dest_tag = tag;
  endtask

  // Issue one op with grant high and expect its broadcast within a bound
  task automatic run_op(input string name, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp);
    bit seen;
    seen = 0;
    drive(op, a, b, tag);
    tick();
    rs_valid = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (cdb_valid) seen = 1;
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
    chk({name, "_tag"}, 32'(cdb_tag), 32'(tag));
    chk({name, "_data"}, cdb_data, exp);
    tick();
  endtask

  initial begin
    int nb;
    logic [4:0] t0;
    logic [4:0] t1;
    bit saw31;

    rst = 1'b1;
    rs_valid = 1'b0;
    alu_opcode = '0;
    alu_op1 = '0;
    alu_op2 = '0;
    alu_dest_tag = '0;
    cdb_grant = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rst_cdb_tag", 32'(cdb_tag), 32'd31);
    chk("rst_cdb_data", cdb_data, 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_ready", 32'(alu_ready), 32'd1);
    chk("rst_req", 32'(cdb_req), 32'd0);

    // Exact minimum latency: E0 accept, E1 push, E2 broadcast
    cdb_grant = 1'b1;
    drive(6'h00, 32'd5, 32'd7, 5'd3);
    tick();
    rs_valid = 1'b0;
    chk("lat_e0_valid", 32'(cdb_valid), 32'd0);
    tick();
    chk("lat_e1_valid", 32'(cdb_valid), 32'd0);
    chk("lat_e1_req", 32'(cdb_req), 32'd1);
    tick();
    chk("lat_e2_valid", 32'(cdb_valid), 32'd1);
    chk("lat_e2_tag", 32'(cdb_tag), 32'd3);
    chk("lat_e2_data", cdb_data, 32'd12);
    chk("lat_e2_req", 32'(cdb_req), 32'd0);
    tick();
    chk("lat_e3_valid", 32'(cdb_valid), 32'd0);
    chk("lat_hold_tag", 32'(cdb_tag), 32'd3);

    run_op("sub",  6'h01, 32'd0, 32'd1, 5'd4, 32'hFFFF_FFFF);
    run_op("slt",  6'h06, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd1);
    run_op("sltu", 6'h07, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd0);
    run_op("slt2", 6'h06, 32'd1, 32'hFFFF_FFFF, 5'd7, 32'd0);
    run_op("sltu2",6'h07, 32'd1, 32'hFFFF_FFFF, 5'd8, 32'd1);
    run_op("sra",  6'h0A, 32'h8000_0000, 32'd4, 5'd9, 32'hF800_0000);
    run_op("srl",  6'h09, 32'h8000_0000, 32'd4, 5'd10, 32'h0800_0000);
    run_op("sll",  6'h08, 32'd1, 32'd33, 5'd11, 32'd2);
    run_op("lui",  6'h0B, 32'd0, 32'hABCD_1234, 5'd12, 32'h1234_0000);
    run_op("addw", 6'h00, 32'hFFFF_FFFF, 32'd2, 5'd13, 32'd1);
    run_op("and",  6'h02, 32'hF0F0, 32'hFF00, 5'd14, 32'h0000_F000);
    run_op("or",   6'h03, 32'hF0F0, 32'hFF00, 5'd15, 32'h0000_FFF0);
    run_op("xor",  6'h04, 32'hF0F0, 32'hFF00, 5'd16, 32'h0000_0FF0);
    run_op("nor",  6'h05, 32'h0, 32'h0, 5'd17, 32'hFFFF_FFFF);

    // Backpressure: grant low, four back-to-back accepts fill the unit
    cdb_grant = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(6'h00, 32'(k * 10), 32'd0, 5'(k));
      tick();
    end
    chk("bp_ready_low", 32'(alu_ready), 32'd0);
    drive(6'h00, 32'd90, 32'd0, 5'd9);
    tick();
    tick();
    rs_valid = 1'b0;
    chk("bp_ready_still", 32'(alu_ready), 32'd0);
    chk("bp_req", 32'(cdb_req), 32'd1);
    chk("bp_no_bcast", 32'(cdb_valid), 32'd0);
    cdb_grant = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("bp_valid", 32'(cdb_valid), 32'd1);
      chk("bp_tag", 32'(cdb_tag), 32'(k));
      chk("bp_data", cdb_data, 32'(k * 10));
    end
    tick();
    chk("bp_no_fifth", 32'(cdb_valid), 32'd0);
    chk("bp_ready_back", 32'(alu_ready), 32'd1);

    // Null tag between 5 and 6 is computed but never broadcast
    nb = 0;
    t0 = '0;
    t1 = '0;
    saw31 = 0;
    drive(6'h00, 32'd1, 32'd1, 5'd5);
    tick();
    drive(6'h00, 32'd2, 32'd2, 5'd31);
    tick();
    drive(6'h00, 32'd3, 32'd3, 5'd6);
    tick();
    rs_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (cdb_valid) begin
        if (nb == 0) t0 = cdb_tag;
        if (nb == 1) t1 = cdb_tag;
        if (cdb_tag == 5'd31) saw31 = 1;
        nb++;
      end
      tick();
    end
    chk("none_count", 32'(nb), 32'd2);
    chk("none_first", 32'(t0), 32'd5);
    chk("none_second", 32'(t1), 32'd6);
    chk("none_no31", 32'(saw31), 32'd0);

    // Illegal opcode: pulse on execute edge, then broadcast zero
    drive(6'h3F, 32'd123, 32'd456, 5'd7);
    tick();
    rs_valid = 1'b0;
    chk("ill_e0", 32'(illegal_op), 32'd0);
    tick();
    chk("ill_pulse", 32'(illegal_op), 32'd1);
    tick();
    chk("ill_clear", 32'(illegal_op), 32'd0);
    chk("ill_valid", 32'(cdb_valid), 32'd1);
    chk("ill_tag", 32'(cdb_tag), 32'd7);
    chk("ill_data", cdb_data, 32'd0);
    tick();

    // Reset with two buffered results discards them
    cdb_grant = 1'b0;
    drive(6'h00, 32'd4, 32'd4, 5'd10);
    tick();
    drive(6'h00, 32'd5, 32'd5, 5'd11);
    tick();
    rs_valid = 1'b0;
    tick();
    chk("pre_rst_req", 32'(cdb_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_req", 32'(cdb_req), 32'd0);
    chk("post_rst_ready", 32'(alu_ready), 32'd1);
    chk("post_rst_valid", 32'(cdb_valid), 32'd0);
    cdb_grant = 1'b1;
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cdb_valid) nb++;
    end
    chk("post_rst_quiet", 32'(nb), 32'd0);
    run_op("post_rst_add", 6'h00, 32'd1, 32'd1, 5'd2, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cdb_unit.md
Name: alu_cdb_unit

Overview:
- Integer execution unit on the consumer side of the reservation-station issue interface.
- Accepts ready operand pairs from the reservation station, computes the result, and buffers it in a small result FIFO.
- Arbitrates for the common data bus (CDB) and broadcasts {tag, data} to every reservation station and the register-status logic.
- Produces the cdb_valid/cdb_tag/cdb_data stream that the reservation stations snoop.

Parameters:
- FIFO_DEPTH, 4, result buffer entries (power of two, >=2).
- NONE, 5'b11111, null tag; results with this tag are never broadcast.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- rs_valid  in  1  issue request from reservation station; operands valid this cycle.
- alu_opcode  in  6  operation select (encoding below).
- alu_op1  in  32  operand 1 (rs value).
- alu_op2  in  32  operand 2 (rt value / immediate).
- alu_dest_tag  in  5  destination tag to broadcast.
- alu_ready  out  1  unit can accept an operation this cycle.
- cdb_req  out  1  request for CDB ownership.
- cdb_grant  in  1  arbiter grant; valid only while cdb_req is high.
- cdb_valid  out  1  broadcast strobe, one cycle per result.
- cdb_tag  out  5  broadcast tag.
- cdb_data  out  32  broadcast result.
- illegal_op  out  1  one-cycle pulse: an unsupported opcode was executed.

Behaviour:
- Reset (rst=1 at posedge): ex-stage valid=0, FIFO empty (pointers and count 0), cdb_valid=0, cdb_tag=NONE, cdb_data=0, illegal_op=0.
  - Reset mid-operation discards in-flight and buffered results; nothing is broadcast afterwards.
- Accept: at a posedge where rs_valid && alu_ready, latch opcode/op1/op2/tag into the ex stage (ex_valid=1). Otherwise ex_valid=0.
  - rs_valid while alu_ready=0 is ignored. The sender must hold the request.
- alu_ready = (fifo_count + ex_valid) < FIFO_DEPTH, computed from registered state only.
  - A same-cycle pop does not raise it.
  - This guarantees a push never hits a full FIFO.
- Execute (next posedge): if ex_valid, compute the result combinationally from ex regs.
  - If ex tag != NONE, push {tag, result}.
  - If ex tag == NONE, drop the result (no push, no broadcast).
- Opcodes:
  - 0x00 ADD: wrap mod 2^32, no overflow trap.
  - 0x01 SUB.
  - 0x02 AND.
  - 0x03 OR.
  - 0x04 XOR.
  - 0x05 NOR.
  - 0x06 SLT: signed, result 0/1.
  - 0x07 SLTU: unsigned.
  - 0x08 SLL: op1 << op2[4:0].
  - 0x09 SRL: logical.
  - 0x0A SRA: arithmetic.
  - 0x0B LUI: op2[15:0] << 16.
  - Any other opcode: result 0, still broadcast, and illegal_op pulses on the execute edge.
- cdb_req = FIFO non-empty (combinational from count).
- Broadcast: at a posedge with cdb_req && cdb_grant, pop the head and register cdb_valid=1, cdb_tag/cdb_data = head.
  - Otherwise cdb_valid=0, while cdb_tag and cdb_data hold their values.
  - cdb_grant while the FIFO is empty is ignored.
- Minimum latency with grant held high: accept at edge E0, push at E1, cdb_valid high during the cycle after E2.
- Throughput: one result per cycle when grant is held high.
- Ordering: strict FIFO; broadcast order equals issue order.
- Simultaneous push and pop at one edge: count unchanged; both pointers advance, wrapping mod FIFO_DEPTH.
- Pop from a single-entry FIFO with simultaneous push: the new entry becomes head next cycle, with no bubble beyond normal.

Test Plan:
- Grant tied 1, ADD op1=5 op2=7 tag=3 -> cdb_valid one cycle after E2, cdb_tag=3, cdb_data=12; cdb_req low afterwards.
- SUB 0-1 tag 4 -> 0xFFFFFFFF. SLT op1=0xFFFFFFFF op2=1 -> 1. SLTU same operands -> 0. SRA 0x80000000 by 4 -> 0xF8000000. LUI op2=0x1234 -> 0x12340000.
- Grant held 0, issue 4 back-to-back ops tags 1..4 -> alu_ready falls after the 4th accept and a 5th rs_valid is not taken. Raising grant broadcasts tags 1,2,3,4 on consecutive cycles, then alu_ready returns to 1.
- Op with tag NONE (31) between tags 5 and 6 -> only 5 and 6 broadcast; no cdb_valid for 31.
- Opcode 0x3F tag 7 -> illegal_op pulse, broadcast tag 7 with data 0.
- Two results buffered, grant 0, assert rst for one cycle -> cdb_req=0, cdb_valid stays 0, alu_ready=1; a subsequent ADD 1+1 tag 2 broadcasts 2.
